// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } mux_state_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // All-ones anode vector for n digits (n <= 8), zero-extended to 8 bits
    function automatic logic [7:0] ANODE_OFF(input int n);
        ANODE_OFF = 8'((1 << n) - 1);
    endfunction

endpackage

// File: rtl/seven_seg.sv
// Hex nibble to active-low segment decoder, bit order {g,f,e,d,c,b,a}.
module seven_seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux_timer.sv
// BLANK/SHOW sequencer with one shared cycle counter; strobes mark the edges
// on which a digit turns on (show_start) or completes its dwell (show_done).
module seg_mux_timer
    import seven_seg_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output mux_state_t state,
    output logic       show_start,
    output logic       show_done
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    assign show_start = (state == BLANK) && en && (cnt == CNT_W'(BLANK_CYCLES - 1));
    assign show_done  = (state == SHOW)  && en && (cnt == CNT_W'(DWELL_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BLANK;
            cnt   <= '0;
        end else begin
            case (state)
                BLANK: begin
                    if (!en) begin
                        cnt <= '0;
                    end else if (show_start) begin
                        state <= SHOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHOW: begin
                    // Dropping en aborts the dwell immediately
                    if (!en || show_done) begin
                        state <= BLANK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_mux.sv
// Time-multiplexes one external seven_seg decoder across N_DIGITS
// common-anode digits, with an all-off blanking gap before every digit.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS     = 2,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 50,
    localparam int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] digits,
    output logic [3:0]            s,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   anode,
    output logic [IDX_W-1:0]      idx,
    output logic                  frame_tick
);

    localparam logic [7:0]          OFF_ALL    = ANODE_OFF(N_DIGITS);
    localparam logic [N_DIGITS-1:0] ANODES_OFF = OFF_ALL[N_DIGITS-1:0];

    mux_state_t            state;
    logic                  show_start;
    logic                  show_done;
    logic [4*N_DIGITS-1:0] shadow;

    seg_mux_timer #(
        .DWELL_CYCLES(DWELL_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .state     (state),
        .show_start(show_start),
        .show_done (show_done)
    );

    function automatic logic [N_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] i);
        logic [N_DIGITS-1:0] a;
        a    = ANODES_OFF;
        a[i] = 1'b0;
        return a;
    endfunction

    // Decoder input tracks shadow[idx] even while blanked so it settles early
    assign s   = shadow[{idx, 2'b00} +: 4];
    assign seg = (state == SHOW) ? seg_in : SEG_OFF;

    always_ff @(posedge clk) begin
        if (!reset) begin
            anode      <= ANODES_OFF;
            idx        <= '0;
            shadow     <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (show_start) begin
                anode <= anode_for(idx);
                // Latch a whole frame only as digit 0 lights, so frames never tear
                if (idx == '0) begin
                    shadow     <= digits;
                    frame_tick <= 1'b1;
                end
            end else if (show_done) begin
                anode <= ANODES_OFF;
                idx   <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else if (!en) begin
                anode <= ANODES_OFF;
                idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux (2 digits, dwell 4, blank 2) driving the real decoder.
module tb_seven_seg_mux;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [7:0] digits;
    logic [3:0] s;
    logic [6:0] seg_in;
    logic [6:0] seg;
    logic [1:0] anode;
    logic [0:0] idx;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    bit inv_on = 1'b0;

    localparam logic [6:0] D_1 = 7'h79, D_2 = 7'h24, D_3 = 7'h30, D_5 = 7'h12;
    localparam logic [6:0] D_A = 7'h08, D_C = 7'h46, OFF = 7'h7F;

    always #5 clk = ~clk;

    seven_seg_mux #(
        .N_DIGITS    (2),
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .digits    (digits),
        .s         (s),
        .seg_in    (seg_in),
        .seg       (seg),
        .anode     (anode),
        .idx       (idx),
        .frame_tick(frame_tick)
    );

    seven_seg u_dec (
        .hex(s),
        .seg(seg_in)
    );

    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            assert ($countones(~anode) <= 1)
            else begin
                errors++;
                $error("FAIL inv_onehot anode=%b", anode);
            end
            if (anode === 2'b11) begin
                checks++;
                assert (seg === OFF)
                else begin
                    errors++;
                    $error("FAIL inv_blank seg=%h required=%h", seg, OFF);
                end
            end
        end
    end

    task automatic step(input string tag, input logic [1:0] ea, input logic [6:0] es,
                        input logic eft, input logic ei, input logic [3:0] exs);
        @(negedge clk);
        checks++;
        assert (anode === ea)
        else begin errors++; $error("FAIL %s anode=%b required=%b", tag, anode, ea); end
        checks++;
        assert (seg === es)
        else begin errors++; $error("FAIL %s seg=%h required=%h", tag, seg, es); end
        checks++;
        assert (frame_tick === eft)
        else begin errors++; $error("FAIL %s frame_tick=%b required=%b", tag, frame_tick, eft); end
        checks++;
        assert (idx === ei)
        else begin errors++; $error("FAIL %s idx=%b required=%b", tag, idx, ei); end
        checks++;
        assert (s === exs)
        else begin errors++; $error("FAIL %s s=%h required=%h", tag, s, exs); end
    endtask

    initial begin
        reset  = 1'b0;
        en     = 1'b1;
        digits = 8'h3A;

        // Reset held for three cycles
        step("rst0", 2'b11, OFF, 1'b0, 1'b0, 4'h0);
        inv_on = 1'b1;
        step("rst1", 2'b11, OFF, 1'b0, 1'b0, 4'h0);
        step("rst2", 2'b11, OFF, 1'b0, 1'b0, 4'h0);
        reset = 1'b1;

        // Frame 1: latch 3A
        step("f1_blank0", 2'b11, OFF, 1'b0, 1'b0, 4'h0);
        step("f1_d0_a", 2'b10, D_A, 1'b1, 1'b0, 4'hA);
        for (int i = 0; i < 3; i++) step("f1_d0_b", 2'b10, D_A, 1'b0, 1'b0, 4'hA);
        for (int i = 0; i < 2; i++) step("f1_blank1", 2'b11, OFF, 1'b0, 1'b1, 4'h3);
        for (int i = 0; i < 4; i++) step("f1_d1", 2'b01, D_3, 1'b0, 1'b1, 4'h3);

        // Frame 2: digits change to 51 during digit 0
        for (int i = 0; i < 2; i++) step("f2_blank0", 2'b11, OFF, 1'b0, 1'b0, 4'hA);
        step("f2_d0_a", 2'b10, D_A, 1'b1, 1'b0, 4'hA);
        digits = 8'h51;
        for (int i = 0; i < 3; i++) step("f2_d0_b", 2'b10, D_A, 1'b0, 1'b0, 4'hA);
        for (int i = 0; i < 2; i++) step("f2_blank1", 2'b11, OFF, 1'b0, 1'b1, 4'h3);
        for (int i = 0; i < 4; i++) step("f2_d1_notear", 2'b01, D_3, 1'b0, 1'b1, 4'h3);

        // Frame 3: shows 1 then 5
        for (int i = 0; i < 2; i++) step("f3_blank0", 2'b11, OFF, 1'b0, 1'b0, 4'hA);
        step("f3_d0_a", 2'b10, D_1, 1'b1, 1'b0, 4'h1);
        for (int i = 0; i < 3; i++) step("f3_d0_b", 2'b10, D_1, 1'b0, 1'b0, 4'h1);
        for (int i = 0; i < 2; i++) step("f3_blank1", 2'b11, OFF, 1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 4; i++) step("f3_d1", 2'b01, D_5, 1'b0, 1'b1, 4'h5);

        // Frame 4: en dropped mid digit 1, new digits during the pause
        for (int i = 0; i < 2; i++) step("f4_blank0", 2'b11, OFF, 1'b0, 1'b0, 4'h1);
        step("f4_d0_a", 2'b10, D_1, 1'b1, 1'b0, 4'h1);
        for (int i = 0; i < 3; i++) step("f4_d0_b", 2'b10, D_1, 1'b0, 1'b0, 4'h1);
        for (int i = 0; i < 2; i++) step("f4_blank1", 2'b11, OFF, 1'b0, 1'b1, 4'h5);
        for (int i = 0; i < 2; i++) step("f4_d1", 2'b01, D_5, 1'b0, 1'b1, 4'h5);
        en     = 1'b0;
        digits = 8'h2C;
        for (int i = 0; i < 5; i++) step("pause", 2'b11, OFF, 1'b0, 1'b0, 4'h1);
        en = 1'b1;
        step("resume_blank", 2'b11, OFF, 1'b0, 1'b0, 4'h1);
        step("resume_d0_a", 2'b10, D_C, 1'b1, 1'b0, 4'hC);
        for (int i = 0; i < 3; i++) step("resume_d0_b", 2'b10, D_C, 1'b0, 1'b0, 4'hC);
        for (int i = 0; i < 2; i++) step("resume_blank1", 2'b11, OFF, 1'b0, 1'b1, 4'h2);
        step("resume_d1", 2'b01, D_2, 1'b0, 1'b1, 4'h2);

        // Reset during digit 1
        reset = 1'b0;
        step("midrst", 2'b11, OFF, 1'b0, 1'b0, 4'h0);
        reset = 1'b1;
        step("post_blank", 2'b11, OFF, 1'b0, 1'b0, 4'h0);
        step("post_d0_a", 2'b10, D_C, 1'b1, 1'b0, 4'hC);
        for (int i = 0; i < 3; i++) step("post_d0_b", 2'b10, D_C, 1'b0, 1'b0, 4'hC);
        for (int i = 0; i < 2; i++) step("post_blank1", 2'b11, OFF, 1'b0, 1'b1, 4'h2);
        step("post_d1", 2'b01, D_2, 1'b0, 1'b1, 4'h2);

        inv_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
